// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// The priority select is used by both the write merge and the read bypass.
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_DEPTH  = 32;
   localparam int RF_MAX_WR = 4;

   function automatic int f_addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Highest-numbered set bit wins; returns 0 when nothing matches.
   function automatic logic [1:0] f_prio_sel(input logic [RF_MAX_WR-1:0] match);
      logic [1:0] sel;
      sel = '0;
      for (int j = 0; j < RF_MAX_WR; j++) begin
         if (match[j]) sel = 2'(j);
      end
      return sel;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: allocation sets, write-back clears, allocation wins.
// Also exports the set of registers whose busy bit drops on the coming edge.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int DEPTH    = RF_DEPTH,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = f_addr_w(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_WR-1:0]    i_wr_en,
   input  logic [NUM_WR*AW-1:0] i_wr_addr,
   input  logic                 i_alloc_en,
   input  logic [AW-1:0]        i_alloc_addr,
   output logic [DEPTH-1:0]     o_busy,
   output logic [DEPTH-1:0]     o_clr_mask
);

   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_clr;
   logic [DEPTH-1:0] r_busy;

   genvar gi, gj;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_bit
         if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign w_set[gi] = 1'b0;
            assign w_clr[gi] = 1'b0;
         end else begin : g_live
            logic [NUM_WR-1:0] w_hit;
            for (gj = 0; gj < NUM_WR; gj++) begin : g_wp
               assign w_hit[gj] = i_wr_en[gj] && (i_wr_addr[gj*AW +: AW] == AW'(gi));
            end
            assign w_set[gi] = i_alloc_en && (i_alloc_addr == AW'(gi));
            assign w_clr[gi] = |w_hit;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_set | (r_busy & ~w_clr);
      end
   end

   assign o_busy     = r_busy;
   assign o_clr_mask = w_clr & ~w_set;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a busy
// scoreboard; reads are combinational, writes and busy updates on the edge.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = f_addr_w(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     alloc_en,
   input  logic [AW-1:0]            alloc_addr
);

   logic [DATA_W-1:0] w_mem [DEPTH];
   logic [DEPTH-1:0]  w_busy_vec;
   logic [DEPTH-1:0]  w_clr_mask;

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_alloc_en   (alloc_en),
      .i_alloc_addr (alloc_addr),
      .o_busy       (w_busy_vec),
      .o_clr_mask   (w_clr_mask)
   );

   genvar gi, gj;
   generate
      // Storage with per-register write merge across all write ports.
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign w_mem[gi] = '0;
         end else begin : g_flop
            logic [NUM_WR-1:0] w_match;
            logic [1:0]        w_sel;
            logic [DATA_W-1:0] r_q;
            for (gj = 0; gj < NUM_WR; gj++) begin : g_wp
               assign w_match[gj] = wr_en[gj] && (wr_addr[gj*AW +: AW] == AW'(gi));
            end
            assign w_sel = f_prio_sel(RF_MAX_WR'(w_match));
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  r_q <= '0;
               end else if (|w_match) begin
                  r_q <= wr_data[int'(w_sel)*DATA_W +: DATA_W];
               end
            end
            assign w_mem[gi] = r_q;
         end
      end

      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [AW-1:0] w_ra;
         logic          w_zero;
         assign w_ra   = rd_addr[gi*AW +: AW];
         assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

         if (BYPASS != 0) begin : g_byp
            logic [NUM_WR-1:0] w_match;
            logic [1:0]        w_sel;
            logic              w_hit;
            logic              w_alloc_hit;
            for (gj = 0; gj < NUM_WR; gj++) begin : g_wp
               assign w_match[gj] = wr_en[gj] && !w_zero && (wr_addr[gj*AW +: AW] == w_ra);
            end
            assign w_sel       = f_prio_sel(RF_MAX_WR'(w_match));
            assign w_hit       = |w_match;
            assign w_alloc_hit = alloc_en && (alloc_addr == w_ra);

            assign rd_data[gi*DATA_W +: DATA_W] =
               (!rd_en[gi] || w_zero) ? '0 :
               w_hit                  ? wr_data[int'(w_sel)*DATA_W +: DATA_W] :
                                        w_mem[w_ra];
            // A same-cycle write retires the producer unless a new one is issued now.
            assign rd_busy[gi] = rd_en[gi] &&
               ((w_busy_vec[w_ra] && !w_clr_mask[w_ra]) || (w_hit && w_alloc_hit));
         end else begin : g_nobyp
            assign rd_data[gi*DATA_W +: DATA_W] =
               (rd_en[gi] && !w_zero) ? w_mem[w_ra] : '0;
            assign rd_busy[gi] = rd_en[gi] && w_busy_vec[w_ra];
         end
      end
   endgenerate

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It is the next generation of the core's 2-read/1-write register file, and it serves pipelines that retire more than one instruction per cycle. It sits between decode (read and allocate) and write-back (write). It adds these over the previous block:
- configurable read and write port counts
- write-to-read bypass
- deterministic write-conflict priority
- hazard tracking through busy bits

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of architectural registers (power of two, ≥ 2)
- NUM_RD, 2, number of read ports
- NUM_WR, 1, number of write ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads

Derived: AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of the addressed register, gated by rd_en
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- alloc_en  in  1  mark a destination register busy (instruction issued)
- alloc_addr  in  AW  register to mark busy

## Operation
- Storage: DEPTH × DATA_W flops, plus a DEPTH-bit busy vector.
- Read port i is combinational.
  - rd_en[i]=0: rd_data slice = 0 and rd_busy[i] = 0.
  - rd_en[i]=1: returns the stored value of rd_addr[i].
- Bypass (BYPASS=1): if any wr_en[j] is set with wr_addr[j]==rd_addr[i] in the same cycle, the read returns that wr_data. The highest-numbered matching write port wins. rd_busy[i] then reads 0 unless alloc_en targets the same address in that cycle.
- BYPASS=0: reads return the pre-edge stored value only.
- Write: on the rising edge, mem[wr_addr[j]] <= wr_data[j] for every enabled port. When several ports target the same address, the highest-numbered port's data is stored.
- ZERO_REG=1: writes to address 0 are ignored, reads of address 0 return 0 (bypass included), and alloc to address 0 is ignored.
- Scoreboard, per register r, on each edge:
  - set when alloc_en && alloc_addr==r
  - else clear when any wr_en[j] && wr_addr[j]==r
  - else hold
- Allocate and write to the same register in the same cycle leaves it busy, because the new producer is pending.
- Writing a register that is not busy is legal; the data updates and busy stays 0.
- Addresses are AW bits wide, so no out-of-range access exists when DEPTH = 2^AW.

## Timing
- Reset (asynchronous assert, synchronous release): all registers = 0 and all busy bits = 0. While rd_en=1, rd_data = 0 and rd_busy = 0 for every address.
- Read latency: 0 cycles (combinational from rd_addr/rd_en, plus wr_* when BYPASS=1).
- Write latency:
  - BYPASS=1: data is visible in the cycle it is written.
  - BYPASS=0: data is visible in the cycle after the edge.
- Busy latency: the busy bit is visible in the cycle after alloc_en. Clear is visible in the same cycle as the write when BYPASS=1, otherwise the cycle after.
- Reset asserted mid-operation clears state immediately. Writes and allocs in the cycle of reset release take effect on the first edge with reset_n=1.

## Structure
- Package rf_pkg holds:
  - default parameter constants (RF_DATA_W=32, RF_DEPTH=32)
  - a function returning AW from DEPTH
  - the priority-select function (highest-index matching write port), shared by the write and bypass logic
- Sub-module rf_scoreboard (DEPTH, NUM_WR, ZERO_REG) owns the busy vector and its set/clear priority, and outputs busy[DEPTH-1:0] plus the next-state clear mask used for bypassed rd_busy.
- Data array, write-merge and read/bypass muxes live in register_file_mp.

## Test plan
- Reset, then read all 32 addresses on both ports with rd_en=1 -> every rd_data = 0 and every rd_busy = 0; with rd_en=0 -> outputs 0 regardless of address.
- Write 0xDEADBEEF to r5, read r5 in the same cycle -> 0xDEADBEEF with BYPASS=1; previous value 0 with BYPASS=0 and 0xDEADBEEF in the next cycle.
- NUM_WR=2: both ports write r7 (port0 0x11111111, port1 0x22222222) -> r7 = 0x22222222, and the same-cycle bypass read also returns 0x22222222.
- Write 0x12345678 to r0 and alloc r0 -> r0 reads 0 and busy[0] stays 0 (ZERO_REG=1). With ZERO_REG=0, r0 reads 0x12345678.
- Alloc r3 -> rd_busy=1 next cycle. Write r3 and alloc r3 in the same cycle -> still busy. Write r3 alone -> busy clears.
- Assert reset_n low between clock edges after writing r9=0xA5A5A5A5 and allocating r9 -> r9 reads 0 and is not busy immediately, without waiting for a clock edge.
